// File: rtl/mire_burst_gen_pkg.sv
// Shared types and constants for the mire test-pattern generator.
// Pattern selects, FSM states and Wishbone cycle type codes.
package mire_pkg;

    typedef enum logic [1:0] {
        MODE_GRID    = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_SOLID   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned widthOf(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mire_burst_gen_pattern.sv
// Combinational pixel generator: maps (x, y, bar, mode) to a {8'h00,R,G,B} word.
// The parent registers the result so the bus sees a clean data word.
module mire_pattern
    import mire_pkg::*;
#(
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [2:0]    bar_i,
    input  mode_e         mode_i,
    input  logic [31:0]   solid_i,
    output logic [31:0]   pixel_o
);

    logic [7:0] x8;
    logic [7:0] y8;
    logic [7:0] sum8;
    logic       chkX;
    logic       chkY;

    always_comb begin
        x8   = 8'(x_i);
        y8   = 8'(y_i);
        sum8 = x8 + y8;
        // The shift-and-mask form picks bit CHECK_LOG2 without a part-select.
        chkX = |((x_i >> CHECK_LOG2) & XW'(1));
        chkY = |((y_i >> CHECK_LOG2) & YW'(1));
        pixel_o = 32'h0;
        case (mode_i)
            MODE_GRID: begin
                if ((x8[4:0] == 5'd0) || (y8[4:0] == 5'd0)) begin
                    pixel_o = 32'hFFFF_FFFF;
                end else begin
                    pixel_o = {8'h00, x8, y8, sum8};
                end
            end
            MODE_BARS: begin
                pixel_o = {8'h00, {8{bar_i[2]}}, {8{bar_i[1]}}, {8{bar_i[0]}}};
            end
            MODE_SOLID: begin
                pixel_o = solid_i;
            end
            MODE_CHECKER: begin
                pixel_o = (chkX ^ chkY) ? 32'hFFFF_FFFF : 32'h0000_0000;
            end
            default: begin
                pixel_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mire_burst_gen.sv
// Wishbone-B4 master that paints a linear framebuffer with a test pattern,
// using fixed-length incrementing bursts separated by an idle gap.
module mire_burst_gen
    import mire_pkg::*;
#(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned GAP_CYCLES = 32,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [31:0] solid_color,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic        we,
    output logic [3:0]  sel,
    output logic        cyc,
    output logic        stb,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int unsigned XW  = widthOf(HDISP);
    localparam int unsigned YW  = widthOf(VDISP);
    localparam int unsigned PW  = widthOf(HDISP * VDISP);
    localparam int unsigned BW  = widthOf(BURST_LEN);
    localparam int unsigned CW  = widthOf(HDISP / 8);
    localparam int unsigned GW  = widthOf(GAP_CYCLES + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(HDISP - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(HDISP * VDISP - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0] BC_LAST   = CW'(HDISP / 8 - 1);
    // A zero gap still spends one cycle with cyc low between bursts.
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    bar_q, bar_d;
    logic [CW-1:0] barCnt_q, barCnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [2:0]    cti_q, cti_d;
    logic          cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic          frameDone_q, frameDone_d;
    logic [15:0]   frameCnt_q, frameCnt_d;

    logic [31:0]   pixel;
    logic          frameEnd;

    mire_pattern #(
        .XW         (XW),
        .YW         (YW),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_pattern (
        .x_i     (x_d),
        .y_i     (y_d),
        .bar_i   (bar_d),
        .mode_i  (mode_d),
        .solid_i (solid_color),
        .pixel_o (pixel)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        x_d      = x_q;
        y_d      = y_q;
        pix_d    = pix_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        bar_d    = bar_q;
        barCnt_d = barCnt_q;
        adr_d    = adr_q;
        frameEnd = (state_q == S_BURST) && ack && (pix_q == PIX_LAST);

        case (state_q)
            S_IDLE: begin
                x_d      = '0;
                y_d      = '0;
                bar_d    = 3'd0;
                barCnt_d = '0;
                if (en) begin
                    state_d = S_BURST;
                    mode_d  = mode_e'(mode);
                end
            end
            S_BURST: begin
                if (ack) begin
                    if (frameEnd) begin
                        x_d      = '0;
                        y_d      = '0;
                        pix_d    = '0;
                        adr_d    = BASE_ADR;
                        bar_d    = 3'd0;
                        barCnt_d = '0;
                    end else begin
                        pix_d = pix_q + PW'(1);
                        adr_d = adr_q + 32'd4;
                        if (x_q == X_LAST) begin
                            x_d      = '0;
                            y_d      = y_q + YW'(1);
                            bar_d    = 3'd0;
                            barCnt_d = '0;
                        end else begin
                            x_d = x_q + XW'(1);
                            if (barCnt_q == BC_LAST) begin
                                barCnt_d = '0;
                                bar_d    = bar_q + 3'd1;
                            end else begin
                                barCnt_d = barCnt_q + CW'(1);
                            end
                        end
                    end
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_GAP;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    // pix_q only sits at zero here once the previous frame has wrapped.
                    if (pix_q != '0) begin
                        state_d = S_BURST;
                    end else if (en) begin
                        state_d = S_BURST;
                        mode_d  = mode_e'(mode);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cyc_d = (state_d == S_BURST);
        if (state_d == S_BURST) begin
            cti_d = (beat_d == BEAT_LAST) ? CTI_END : CTI_INCR;
        end else begin
            cti_d = CTI_CLASSIC;
        end
        dat_d       = (cyc_q && !ack) ? dat_q : pixel;
        busy_d      = (state_d != S_IDLE);
        frameDone_d = frameEnd;
        frameCnt_d  = frameCnt_q + 16'(frameEnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_GRID;
            x_q         <= '0;
            y_q         <= '0;
            pix_q       <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            bar_q       <= 3'd0;
            barCnt_q    <= '0;
            adr_q       <= BASE_ADR;
            dat_q       <= 32'h0;
            cti_q       <= CTI_CLASSIC;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= 16'h0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            bar_q       <= bar_d;
            barCnt_q    <= barCnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cti_q       <= cti_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
            frameCnt_q  <= frameCnt_d;
        end
    end

    assign adr        = adr_q;
    assign dat_ms     = dat_q;
    assign we         = 1'b1;
    assign sel        = 4'b1111;
    assign cyc        = cyc_q;
    assign stb        = cyc_q;
    assign cti        = cti_q;
    assign bte        = 2'b00;
    assign busy       = busy_q;
    assign frame_done = frameDone_q;
    assign frame_cnt  = frameCnt_q;

endmodule

// File: tb/tb_mire_burst_gen.sv
// Self-checking bench for mire_burst_gen on a 16x4 framebuffer with 4-beat bursts.
// Expected pixels come from a per-index arithmetic model of the four patterns.
module tb_mire_burst_gen;
    import mire_pkg::*;

    localparam int unsigned HD   = 16;
    localparam int unsigned VD   = 4;
    localparam int unsigned BL   = 4;
    localparam int unsigned GAP  = 2;
    localparam int unsigned CL2  = 2;
    localparam logic [31:0] BASE = 32'h1000;
    localparam int          NPIX = HD * VD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] solid_color;
    logic        ack;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int          total = 0;
    int          bad = 0;
    int          idleRun = 0;
    logic        prevCyc = 1'b0;
    int          framePulses = 0;
    logic [31:0] px0;
    logic [31:0] px17;
    logic [31:0] line0 [HD];
    bit          found;

    always #5 clk = ~clk;

    mire_burst_gen #(
        .HDISP      (HD),
        .VDISP      (VD),
        .BASE_ADR   (BASE),
        .BURST_LEN  (BL),
        .GAP_CYCLES (GAP),
        .CHECK_LOG2 (CL2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .solid_color (solid_color),
        .adr         (adr),
        .dat_ms      (dat_ms),
        .we          (we),
        .sel         (sel),
        .cyc         (cyc),
        .stb         (stb),
        .cti         (cti),
        .bte         (bte),
        .ack         (ack),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    // Pixel k of a frame, computed from its (x, y) coordinates.
    function automatic logic [31:0] refPixel(input int m, input int k, input logic [31:0] solid);
        int x;
        int y;
        int b;
        x = k % HD;
        y = k / HD;
        case (m)
            0: begin
                if ((x % 32 == 0) || (y % 32 == 0)) return 32'hFFFF_FFFF;
                return {8'h00, 8'(x % 256), 8'(y % 256), 8'((x + y) % 256)};
            end
            1: begin
                b = x / (HD / 8);
                return {8'h00, ((b & 4) != 0) ? 8'hFF : 8'h00,
                        ((b & 2) != 0) ? 8'hFF : 8'h00, ((b & 1) != 0) ? 8'hFF : 8'h00};
            end
            2: return solid;
            default: return ((((x / (1 << CL2)) + (y / (1 << CL2))) % 2) == 1) ? 32'hFFFF_FFFF : 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the Wishbone slave for one whole frame, checking every accepted beat.
    // waitPat: 0 = ack every cycle, 1 = random wait states, 2 = three waits on beat 2.
    task automatic applyStimulus(input int expMode, input int waitPat, input bit fromGap,
                                 input int changeAt, input logic [1:0] newMode, input logic newEn);
        int          k = 0;
        int          waits = 0;
        int          cycles = 0;
        bit          holding = 0;
        bit          done = 0;
        bit          doWait;
        logic [31:0] hAdr;
        logic [31:0] hDat;
        logic [2:0]  hCti;
        while (!done && cycles < 4000) begin
            tick();
            cycles++;
            if (cyc) begin
                if (!prevCyc && (k > 0 || fromGap)) checkOutput("gapLen", 32'(idleRun), 32'(GAP));
                idleRun = 0;
                checkOutput("stb", 32'(stb), 32'd1);
                if (holding) begin
                    checkOutput("holdAdr", adr, hAdr);
                    checkOutput("holdDat", dat_ms, hDat);
                    checkOutput("holdCti", 32'(cti), 32'(hCti));
                end
                doWait = 0;
                if (waitPat == 2) doWait = (k % BL == 2) && (waits < 3);
                else if (waitPat == 1) doWait = (waits < 3) && ($urandom_range(0, 2) == 0);
                if (doWait) begin
                    ack = 1'b0;
                    holding = 1;
                    hAdr = adr;
                    hDat = dat_ms;
                    hCti = cti;
                    waits++;
                end else begin
                    ack = 1'b1;
                    holding = 0;
                    waits = 0;
                    checkOutput("adr", adr, BASE + 32'(4 * k));
                    checkOutput("dat", dat_ms, refPixel(expMode, k, solid_color));
                    checkOutput("cti", 32'(cti), (k % BL == BL - 1) ? 32'b111 : 32'b010);
                    if (k == 0) px0 = dat_ms;
                    if (k == HD + 1) px17 = dat_ms;
                    if (k < HD) line0[k] = dat_ms;
                    k++;
                    if (k == changeAt) begin
                        mode = newMode;
                        en = newEn;
                    end
                end
            end else begin
                ack = 1'b0;
                holding = 0;
                idleRun++;
            end
            prevCyc = cyc;
            if (frame_done) begin
                framePulses++;
                done = 1;
            end
        end
        checkOutput("frameDoneSeen", 32'(done), 32'd1);
        checkOutput("beatsPerFrame", 32'(k), 32'(NPIX));
    endtask

    task automatic expectIdle(input string tag);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput({tag, "Cyc"}, 32'(cyc), 32'd0);
            checkOutput({tag, "FrameDoneLow"}, 32'(frame_done), 32'd0);
        end
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        prevCyc = 1'b0;
        idleRun = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        ack = 1'b0;
        mode = 2'd0;
        solid_color = 32'h0;
        repeat (3) tick();
        checkOutput("rstCyc", 32'(cyc), 32'd0);
        checkOutput("rstStb", 32'(stb), 32'd0);
        checkOutput("rstAdr", adr, BASE);
        checkOutput("rstDat", dat_ms, 32'h0);
        checkOutput("rstCti", 32'(cti), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
        checkOutput("rstFrameCnt", 32'(frame_cnt), 32'd0);
        checkOutput("constWe", 32'(we), 32'd1);
        checkOutput("constSel", 32'(sel), 32'hF);
        checkOutput("constBte", 32'(bte), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idleCyc", 32'(cyc), 32'd0);
        end
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleAdr", adr, BASE);
        checkOutput("idleFrameCnt", 32'(frame_cnt), 32'd0);

        $display("[TB] frame A: GRID, ack every cycle");
        mode = MODE_GRID;
        en = 1'b1;
        applyStimulus(0, 0, 0, -1, 2'd0, 1'b1);
        checkOutput("gridPix00", px0, 32'hFFFF_FFFF);
        checkOutput("gridPix11", px17, 32'h0001_0102);
        checkOutput("frameCntA", 32'(frame_cnt), 32'd1);
        checkOutput("busyA", 32'(busy), 32'd1);

        $display("[TB] frame B: BARS, three waits on beat 2");
        mode = MODE_BARS;
        applyStimulus(1, 2, 1, -1, 2'd0, 1'b1);
        checkOutput("barsX2", line0[2], 32'h0000_00FF);
        checkOutput("barsX7", line0[7], 32'h0000_FFFF);
        checkOutput("barsX15", line0[15], 32'h00FF_FFFF);
        checkOutput("frameCntB", 32'(frame_cnt), 32'd2);

        $display("[TB] frame C: CHECKER, random waits");
        mode = MODE_CHECKER;
        applyStimulus(3, 1, 1, -1, 2'd0, 1'b1);
        checkOutput("frameCntC", 32'(frame_cnt), 32'd3);

        $display("[TB] frame D: BARS, mode and en changed mid-frame");
        mode = MODE_BARS;
        solid_color = 32'h0012_3456;
        applyStimulus(1, 1, 1, 20, 2'd2, 1'b0);
        checkOutput("frameCntD", 32'(frame_cnt), 32'd4);
        expectIdle("afterD");

        $display("[TB] frame E: SOLID from idle, random colour");
        solid_color = $urandom;
        mode = MODE_SOLID;
        en = 1'b1;
        applyStimulus(2, 1, 0, 40, 2'd2, 1'b0);
        checkOutput("frameCntE", 32'(frame_cnt), 32'd5);
        expectIdle("afterE");

        $display("[TB] reset during beat 1");
        mode = MODE_GRID;
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (cyc) found = 1;
        end
        checkOutput("burstStarted", 32'(found), 32'd1);
        ack = 1'b1;
        tick();
        checkOutput("beat1Adr", adr, BASE + 32'd4);
        ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstCyc", 32'(cyc), 32'd0);
        checkOutput("asyncRstStb", 32'(stb), 32'd0);
        en = 1'b0;
        repeat (2) tick();
        checkOutput("inRstAdr", adr, BASE);
        checkOutput("inRstFrameCnt", 32'(frame_cnt), 32'd0);
        checkOutput("inRstBusy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        checkOutput("postRstCyc", 32'(cyc), 32'd0);
        checkOutput("postRstAdr", adr, BASE);
        checkOutput("postRstFrameCnt", 32'(frame_cnt), 32'd0);

        $display("[TB] frame G: GRID after reset, random waits");
        prevCyc = 1'b0;
        idleRun = 0;
        mode = MODE_GRID;
        en = 1'b1;
        applyStimulus(0, 1, 0, 10, 2'd0, 1'b0);
        checkOutput("frameCntG", 32'(frame_cnt), 32'd1);
        expectIdle("afterG");
        checkOutput("framePulses", 32'(framePulses), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mire_burst_gen.md
Name: mire_burst_gen

Overview:
- Parametrised Wishbone-B4 master test-pattern generator.
- Fills a linear HDISP x VDISP framebuffer at BASE_ADR with one of four selectable patterns.
- Uses incrementing bursts with a programmable idle gap between bursts so the SDRAM arbiter can serve the VGA reader.
- Sits beside the video reader on the framebuffer Wishbone crossbar; runs frame after frame while enabled.

Parameters:
- HDISP, 800, active pixels per line; must be a multiple of 8.
- VDISP, 480, active lines per frame.
- BASE_ADR, 32'h0, byte address of pixel (0,0); must be 4-byte aligned.
- BURST_LEN, 8, words per Wishbone burst; power of 2; HDISP*VDISP must be a multiple of BURST_LEN.
- GAP_CYCLES, 32, idle cycles with cyc=0 after each burst; 0 allowed (next burst starts the cycle after the gap state would have begun).
- CHECK_LOG2, 5, checkerboard square size is 2**CHECK_LOG2 pixels.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, run request.
- mode, in, 2, pattern select: 0 GRID, 1 BARS, 2 SOLID, 3 CHECKER.
- solid_color, in, 32, pixel value used in SOLID mode.
- adr, out, 32, Wishbone byte address.
- dat_ms, out, 32, write data.
- we, out, 1, constant 1.
- sel, out, 4, constant 4'b1111.
- cyc, out, 1, bus cycle.
- stb, out, 1, strobe.
- cti, out, 3, cycle type identifier.
- bte, out, 2, constant 2'b00 (linear).
- ack, in, 1, slave acknowledge.
- busy, out, 1, high while a frame is in progress.
- frame_done, out, 1, one-cycle pulse at end of each frame.
- frame_cnt, out, 16, completed frames, wraps at 16'hFFFF.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state IDLE; x, y, pixel index, burst count, gap count = 0;
  - cyc = stb = 0; adr = BASE_ADR; dat_ms = 0; cti = 3'b000;
  - busy = 0; frame_done = 0; frame_cnt = 0.
- Reset asserted mid-burst drops cyc/stb immediately; no completion of the burst.
- FSM states: IDLE, BURST, GAP.
- IDLE:
  - en=1 -> BURST next cycle.
  - mode is latched at this transition only; mode changes mid-frame are ignored until the next frame.
  - x = y = 0.
- BURST:
  - cyc = stb = 1.
  - cti = 3'b010 for beats 0..BURST_LEN-2 and 3'b111 on the last beat; if BURST_LEN=1, cti = 3'b111.
  - adr, dat_ms and cti are held stable while stb=1 and ack=0.
  - Each ack advances x, and wraps x at HDISP-1 with y+1.
  - Each ack also advances the pixel index and burst count.
  - adr = BASE_ADR + 4*pixel_index, computed incrementally by adding 4 per ack, with no multiplier.
  - ack on the last beat -> GAP; cyc = stb = 0 the next cycle.
- GAP:
  - Count GAP_CYCLES idle cycles, then start the next burst.
  - If the last burst ended at pixel (HDISP-1, VDISP-1), after the gap:
    - en=1 -> new frame, mode relatched;
    - en=0 -> IDLE.
- Frame end:
  - frame_done pulses in the cycle after the ack of the last pixel.
  - frame_cnt increments in the same cycle; x, y, pixel index and adr return to 0 / BASE_ADR.
- en deassert mid-frame: the frame completes; en is re-examined only at the frame boundary.
- busy = (state != IDLE).
- Pixel data is registered and must correspond to the current (x, y) whenever stb=1. Patterns, with pixel format {8'h00,R,G,B}:
  - GRID: 32'hFFFFFFFF if x[4:0]==0 or y[4:0]==0, else {8'h00, x[7:0], y[7:0], x[7:0]+y[7:0]} (8-bit wrap).
  - BARS:
    - bar index b = 0..7 advances every HDISP/8 pixels along the line, using a counter (no divide) that resets at each line start.
    - pixel = {8'h00, b[2]?FF:00, b[1]?FF:00, b[0]?FF:00}.
  - SOLID: solid_color, sampled each pixel.
  - CHECKER: 32'hFFFFFFFF if x[CHECK_LOG2]^y[CHECK_LOG2], else 32'h00000000.
- Counter widths are $clog2 of HDISP and VDISP; the pixel index width is $clog2(HDISP*VDISP).

Decomposition:
- Package mire_pkg holds:
  - typedef enum mode_e {MODE_GRID, MODE_BARS, MODE_SOLID, MODE_CHECKER};
  - typedef enum state_e {S_IDLE, S_BURST, S_GAP};
  - constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_END = 3'b111.
- One sub-module, mire_pattern:
  - inputs: x, y, bar index, latched mode, solid_color;
  - output: combinational 32-bit pixel;
  - mire_burst_gen registers that pixel.

Test Plan (HDISP=16, VDISP=4, BURST_LEN=4, GAP_CYCLES=2, BASE_ADR=32'h1000, slave acks every cycle unless stated):
- Reset release, en=0 for 20 cycles -> cyc=0, busy=0, adr=32'h1000, frame_cnt=0.
- en=1, mode=GRID, one frame -> 16 bursts of 4 beats each, with cti 010,010,010,111 per burst.
  - Exactly 2 idle cyc=0 cycles between bursts.
  - Addresses 0x1000..0x10FC, consecutive.
  - Pixel (0,0) = FFFFFFFF; pixel (1,1) = 00010102.
  - frame_done pulses once; frame_cnt = 1.
- Slave inserts 3 wait states on beat 2 -> adr, dat_ms and cti are unchanged during the waits; beat order is preserved.
- mode=BARS -> line 0 data: 2 pixels each of 00000000, 000000FF, 0000FF00, 0000FFFF, 00FF0000, 00FF00FF, 00FFFF00, 00FFFFFF.
- Switch mode to SOLID (solid_color=0x00123456) mid-frame, and drop en mid-frame:
  - the current frame keeps its latched pattern and completes;
  - then the block goes IDLE with busy=0.
- Assert rst_n=0 during beat 1 of a burst -> cyc and stb fall asynchronously; after release the block restarts at adr 0x1000, frame_cnt=0.
